clk_gate_ctrl: RTL
==================

// Module: clk_gate_ctrl
// PURPOSE
//  Power controller and arbiter for one gated clock domain (e.g. ALU/RegFile).
//  Grants up to NUM_REQ requesters access to the domain round-robin.
//  Drives the enable of the latch-based clock-gate cell: wakes the domain before the first grant,
//  and gates it off after an idle timeout.
//  o_Gate_EN is registered on i_Ref_clk, so the gate latch only ever sees a clean, glitch-free enable.
// PARAMETERS
//  NUM_REQ      2  number of requesters (>=2)
//  WAKE_CYCLES  2  cycles o_Gate_EN is high before the first grant (>=1)
//  IDLE_CYCLES  4  idle cycles with clock still running before gating off (>=1)
// PORTS
//  i_Ref_clk   in   1        ungated reference clock; all logic on its rising edge
//  i_RST_n     in   1        asynchronous reset, active-low
//  i_Req       in   NUM_REQ  per-requester access request, level, held until done
//  i_Force_On  in   1        keep domain clock running, ignoring the idle timeout
//  o_Gate_EN   out  1        enable to the clock-gate cell
//  o_Gnt       out  NUM_REQ  one-hot grant (all-zero = none)
//  o_Busy      out  1        1 in any state except OFF
//  o_State     out  2        OFF=0, WAKE=1, ON=2, IDLE=3 (debug)
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - state OFF, o_Gate_EN=0, o_Gnt=0, counter=0, rr pointer=0 (req0 highest priority).
//  All outputs are registered; counter width is $clog2(max(WAKE_CYCLES,IDLE_CYCLES)+1).
//  OFF
//   - |i_Req or i_Force_On sampled 1 -> WAKE. o_Gate_EN=1 and counter=WAKE_CYCLES on that edge.
//  WAKE
//   - counter decrements each cycle; o_Gnt stays 0.
//   - When counter==1 on an edge: ->ON, and a grant is issued on the same edge if any i_Req is high.
//   - WAKE always completes, even if requests drop: WAKE is exactly WAKE_CYCLES cycles.
//  ON
//   - Arbitration: the grant goes to the first requesting index at or after the rr pointer, wrapping.
//   - A grant holds while its i_Req stays 1 (no preemption).
//   - When the granted i_Req is sampled 0, on that edge:
//       o_Gnt moves to the next requester (search from grantee+1, wrap) or goes to 0;
//       rr pointer = grantee+1 mod NUM_REQ.
//   - If ON with o_Gnt==0 and no i_Req is sampled:
//       i_Force_On=0 -> IDLE, counter=IDLE_CYCLES;
//       i_Force_On=1 -> stay ON.
//  IDLE (o_Gate_EN still 1, o_Gnt=0)
//   - Any i_Req -> ON, with the grant issued on the same edge (no wake latency).
//   - i_Force_On -> ON without a grant.
//   - Otherwise counter decrements. On the edge where counter==1: ->OFF, o_Gate_EN=0.
//   - A request arriving in the same cycle as expiry wins: go to ON, not OFF.
//  Simultaneous requests: rr order decides; exactly one bit of o_Gnt is set at any time.
//  Invariant: o_Gnt!=0 implies o_Gate_EN==1 and state==ON.
//  Reset mid-operation: immediate return to reset values; o_Gate_EN drops asynchronously.
// TESTING
//  T1 Reset: hold i_RST_n=0 with i_Req=2'b11.
//     -> o_Gate_EN=0, o_Gnt=0, o_State=0, o_Busy=0.
//  T2 Wake latency: WAKE_CYCLES=2, i_Req=01 at edge k.
//     -> o_Gate_EN=1 after edge k; o_Gnt=01 after edge k+2.
//  T3 Round-robin: i_Req=11 held, req0 granted, then req0 drops.
//     -> o_Gnt=10 on the next edge. req0 re-raised -> granted only after req1 drops.
//  T4 Idle timeout: all requests drop, IDLE_CYCLES=4.
//     -> IDLE for 4 cycles, then o_Gate_EN=0, o_State=OFF. No o_Gate_EN glitch in between.
//  T5 Rescue from IDLE: i_Req=10 on the expiry edge.
//     -> ON, o_Gnt=10 immediately, o_Gate_EN stays 1.
//  T6 Force/reset: i_Force_On=1 with no requests.
//     -> stays ON indefinitely. Then i_RST_n=0 mid-grant -> o_Gnt=0, o_Gate_EN=0 asynchronously.

Source files
------------

// File: rtl/clk_gate_ctrl.sv
// Clock-gate power controller with round-robin arbiter for one gated domain.
// Wakes the domain ahead of the first grant and gates it off after an idle timeout.
module clk_gate_ctrl #(
  parameter int NUM_REQ     = 2,
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 4
) (
  input  logic               i_Ref_clk,
  input  logic               i_RST_n,
  input  logic [NUM_REQ-1:0] i_Req,
  input  logic               i_Force_On,
  output logic               o_Gate_EN,
  output logic [NUM_REQ-1:0] o_Gnt,
  output logic               o_Busy,
  output logic [1:0]         o_State
);

  localparam int MAXC = (WAKE_CYCLES > IDLE_CYCLES) ?
                        WAKE_CYCLES : IDLE_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam int PW = $clog2(NUM_REQ);

  localparam logic [CW-1:0] WAKE_LD = CW'(WAKE_CYCLES);
  localparam logic [CW-1:0] IDLE_LD = CW'(IDLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    ON   = 2'd2,
    IDLE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic               gate_q, gate_d;
  logic               busy_q, busy_d;
  logic [PW-1:0]      ptr_nxt;

  function automatic logic [NUM_REQ-1:0] rr_pick(
    input logic [NUM_REQ-1:0] req,
    input logic [PW-1:0]      start
  );
    logic [NUM_REQ-1:0] g;
    int idx;
    g = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(start) + k) % NUM_REQ;
      if (req[idx] && (g == '0)) g[idx] = 1'b1;
    end
    return g;
  endfunction

  // Pointer slot just past the current grantee.
  always_comb begin
    int gi;
    gi = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_q[k]) gi = k;
    end
    ptr_nxt = PW'((gi + 1) % NUM_REQ);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    gate_d  = gate_q;
    unique case (state_q)
      OFF: begin
        if (|i_Req || i_Force_On) begin
          state_d = WAKE;
          gate_d  = 1'b1;
          cnt_d   = WAKE_LD;
        end
      end
      WAKE: begin
        if (cnt_q == CNT_ONE) begin
          state_d = ON;
          gnt_d   = rr_pick(i_Req, ptr_q);
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ON: begin
        if (|gnt_q) begin
          if (!(|(gnt_q & i_Req))) begin
            ptr_d = ptr_nxt;
            gnt_d = rr_pick(i_Req, ptr_nxt);
          end
        end else if (|i_Req) begin
          gnt_d = rr_pick(i_Req, ptr_q);
        end else if (!i_Force_On) begin
          state_d = IDLE;
          cnt_d   = IDLE_LD;
        end
      end
      IDLE: begin
        // A request on the expiry edge rescues the domain.
        if (|i_Req) begin
          state_d = ON;
          gnt_d   = rr_pick(i_Req, ptr_q);
        end else if (i_Force_On) begin
          state_d = ON;
        end else if (cnt_q == CNT_ONE) begin
          state_d = OFF;
          gate_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = OFF;
    endcase
    busy_d = (state_d != OFF);
  end

  always_ff @(posedge i_Ref_clk or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q <= OFF;
      cnt_q   <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
      gate_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      gate_q  <= gate_d;
      busy_q  <= busy_d;
    end
  end

  assign o_Gate_EN = gate_q;
  assign o_Gnt     = gnt_q;
  assign o_Busy    = busy_q;
  assign o_State   = state_q;

endmodule
